// File: rtl/dual_rail_word_receiver.sv
// Clocked receiver for a single NCL dual-rail bit stream: synchronises the rails, runs the
// four-phase NULL/DATA completion handshake, packs bits LSB-first into words and queues them.
module dual_rail_word_receiver #(
  parameter int WORD_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       init,
  input  logic [1:0]                 dualC,
  output logic                       dualCCOMP,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       rail_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  localparam logic [1:0] S_WAIT_NULL  = 2'd0;
  localparam logic [1:0] S_FULL_CHECK = 2'd1;
  localparam logic [1:0] S_REQ_DATA   = 2'd2;

  // Synchroniser and compare flops keep tracking the rails through init, so a DATA code
  // still held upstream after reset is seen as stable DATA, never as a fresh NULL.
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] cmp_q;

  // NOTE: every clocked register is written with <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    sync_q[0] <= dualC;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
    cmp_q <= sync_q[SYNC_STAGES-1];
  end

  logic [1:0] code;
  logic       stable;
  logic       is_null;
  logic       is_data;
  logic       is_bad;

  assign code    = sync_q[SYNC_STAGES-1];
  assign stable  = (code == cmp_q);
  assign is_null = stable && (code == 2'b00);
  assign is_data = stable && (code[1] ^ code[0]);
  assign is_bad  = stable && (code == 2'b11);

  logic [1:0]        state_q,    state_d;
  logic              comp_q,     comp_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [WORD_W-1:0] shift_q,    shift_d;
  logic              rail_err_q, rail_err_d;
  logic [WORD_W-1:0] word_d;
  logic              push;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              pop;
  logic              full;

  assign full = (count_q == FULL_LVL);
  assign pop  = (count_q != '0) && out_ready;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    comp_d     = comp_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rail_err_d = rail_err_q | is_bad;
    push       = 1'b0;
    word_d     = shift_q;
    word_d[bit_cnt_q] = code[1];

    case (state_q)
      S_WAIT_NULL: begin
        if (is_null) state_d = S_FULL_CHECK;
      end
      S_FULL_CHECK: begin
        if (!full) begin
          state_d = S_REQ_DATA;
          comp_d  = 1'b0;
        end
      end
      S_REQ_DATA: begin
        if (is_data) begin
          shift_d = word_d;
          comp_d  = 1'b1;
          state_d = S_WAIT_NULL;
          if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_WAIT_NULL;
        comp_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= S_WAIT_NULL;
      comp_q     <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rail_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      comp_q     <= comp_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rail_err_q <= rail_err_d;
    end
  end

  // Push only happens from REQ_DATA, which is entered only when not full, so no overflow guard.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is cleared on init so out_data reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= word_d;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign dualCCOMP  = comp_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign rail_err   = rail_err_q;

endmodule

// File: tb/tb_dual_rail_word_receiver.sv
// Directed bench for dual_rail_word_receiver: handshake timing, word packing, FIFO
// back-pressure, simultaneous push/pop, illegal rail code and reset mid-handshake.
module tb_dual_rail_word_receiver;

  localparam int WORD_W      = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int LAT         = SYNC_STAGES + 2;

  logic              clk = 1'b0;
  logic              init;
  logic [1:0]        dualC;
  logic              dualCCOMP;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  fifo_count;
  logic              rail_err;

  int n_vec = 0;
  int n_err = 0;

  dual_rail_word_receiver #(
    .WORD_W     (WORD_W),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .init      (init),
    .dualC     (dualC),
    .dualCCOMP (dualCCOMP),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_count(fifo_count),
    .rail_err  (rail_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One handshake: wait for request, drive DATA, measure cycles until completion, return to NULL.
  // lat = -1 when either wait expires.
  task automatic send_bit(input logic b, output int lat);
    int n;
    lat = -1;
    n   = 0;
    while (dualCCOMP !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (dualCCOMP !== 1'b0) return;
    dualC = b ? 2'b10 : 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dualCCOMP !== 1'b1 && n < 50);
    if (dualCCOMP === 1'b1) lat = n;
    dualC = 2'b00;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, output int bad);
    int lat;
    bad = 0;
    for (int i = 0; i < WORD_W; i++) begin
      send_bit(w[i], lat);
      if (lat != LAT) bad++;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    dualC     = 2'b00;
    out_ready = 1'b0;
    init      = 1'b1;
    repeat (3) @(negedge clk);
    init = 1'b0;
    n_vec++;
    if (dualCCOMP !== 1'b1) begin
      $display("FAIL reset_comp: got %b want 1", dualCCOMP); n_err++;
    end
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== '0) begin
      $display("FAIL reset_fifo: valid %b count %0d want 0 0", out_valid, fifo_count); n_err++;
    end
    n_vec++;
    if (rail_err !== 1'b0 || out_data !== '0) begin
      $display("FAIL reset_misc: rail_err %b data %h want 0 00", rail_err, out_data); n_err++;
    end
    n = 0;
    while (dualCCOMP !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n != 2) begin
      $display("FAIL reset_request_delay: got %0d cycles want 2", n); n_err++;
    end
  endtask

  task automatic test_word_pack();
    logic [WORD_W-1:0] bits;
    int lat;
    bits = 8'h4D;
    for (int i = 0; i < WORD_W; i++) begin
      send_bit(bits[i], lat);
      n_vec++;
      if (lat != LAT) begin
        $display("FAIL pack_latency bit%0d: got %0d want %0d", i, lat, LAT); n_err++;
      end
    end
    n_vec++;
    if (out_data !== 8'h4D || out_valid !== 1'b1 || fifo_count !== CNT_W'(1)) begin
      $display("FAIL pack_word: data %h valid %b count %0d want 4d 1 1",
               out_data, out_valid, fifo_count); n_err++;
    end
    pop_one();
    n_vec++;
    if (fifo_count !== '0 || out_valid !== 1'b0) begin
      $display("FAIL pack_pop: count %0d valid %b want 0 0", fifo_count, out_valid); n_err++;
    end
  endtask

  task automatic test_backpressure();
    logic [WORD_W-1:0] words [5];
    int bad;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h01; words[3] = 8'hFF; words[4] = 8'h80;
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      send_word(words[k], bad);
      n_vec++;
      if (bad != 0) begin
        $display("FAIL fill_word%0d: %0d bad handshakes want 0", k, bad); n_err++;
      end
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (fifo_count !== CNT_W'(DEPTH) || dualCCOMP !== 1'b1) begin
      $display("FAIL full_hold: count %0d comp %b want %0d 1", fifo_count, dualCCOMP, DEPTH); n_err++;
    end
    n_vec++;
    if (out_data !== words[0]) begin
      $display("FAIL full_head: got %h want %h", out_data, words[0]); n_err++;
    end
    pop_one();
    send_word(words[4], bad);
    n_vec++;
    if (bad != 0 || fifo_count !== CNT_W'(DEPTH)) begin
      $display("FAIL resume_word5: bad %0d count %0d want 0 %0d", bad, fifo_count, DEPTH); n_err++;
    end
    for (int k = 1; k < 5; k++) begin
      n_vec++;
      if (out_data !== words[k]) begin
        $display("FAIL order_word%0d: got %h want %h", k, out_data, words[k]); n_err++;
      end
      pop_one();
    end
    n_vec++;
    if (fifo_count !== '0) begin
      $display("FAIL drain_count: got %0d want 0", fifo_count); n_err++;
    end
  endtask

  task automatic test_push_pop();
    logic [WORD_W-1:0] w_c;
    int bad;
    int lat;
    int n;
    w_c = 8'h56;
    send_word(8'h12, bad);
    send_word(8'h34, bad);
    for (int i = 0; i < WORD_W - 1; i++) send_bit(w_c[i], lat);
    n = 0;
    while (dualCCOMP !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (fifo_count !== CNT_W'(2) || out_data !== 8'h12) begin
      $display("FAIL pp_pre: count %0d head %h want 2 12", fifo_count, out_data); n_err++;
    end
    dualC = w_c[WORD_W-1] ? 2'b10 : 2'b01;
    repeat (LAT - 1) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (dualCCOMP !== 1'b1 || fifo_count !== CNT_W'(2) || out_data !== 8'h34) begin
      $display("FAIL pp_same_cycle: comp %b count %0d head %h want 1 2 34",
               dualCCOMP, fifo_count, out_data); n_err++;
    end
    dualC = 2'b00;
    pop_one();
    n_vec++;
    if (out_data !== 8'h56) begin
      $display("FAIL pp_tail: got %h want 56", out_data); n_err++;
    end
    pop_one();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (fifo_count !== '0 || out_valid !== 1'b0) begin
      $display("FAIL pop_empty: count %0d valid %b want 0 0", fifo_count, out_valid); n_err++;
    end
  endtask

  task automatic test_rail_error();
    logic [WORD_W-1:0] w;
    int lat;
    int n;
    w = 8'hC6;
    n = 0;
    while (dualCCOMP !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    dualC = 2'b11;
    repeat (LAT) @(negedge clk);
    n_vec++;
    if (rail_err !== 1'b1 || dualCCOMP !== 1'b0 || fifo_count !== '0) begin
      $display("FAIL illegal_code: err %b comp %b count %0d want 1 0 0",
               rail_err, dualCCOMP, fifo_count); n_err++;
    end
    for (int i = 0; i < WORD_W; i++) begin
      send_bit(w[i], lat);
      n_vec++;
      if (lat != LAT) begin
        $display("FAIL err_recover_bit%0d: latency %0d want %0d", i, lat, LAT); n_err++;
      end
    end
    n_vec++;
    if (out_data !== 8'hC6 || fifo_count !== CNT_W'(1) || rail_err !== 1'b1) begin
      $display("FAIL err_word: data %h count %0d err %b want c6 1 1",
               out_data, fifo_count, rail_err); n_err++;
    end
    pop_one();
  endtask

  task automatic test_reset_mid_word();
    int lat;
    int bad;
    int n;
    for (int i = 0; i < 3; i++) send_bit(1'b1, lat);
    n = 0;
    while (dualCCOMP !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    dualC = 2'b10;
    repeat (2) @(negedge clk);
    init = 1'b1;
    repeat (2) @(negedge clk);
    init = 1'b0;
    n_vec++;
    if (dualCCOMP !== 1'b1 || rail_err !== 1'b0) begin
      $display("FAIL midreset_state: comp %b err %b want 1 0", dualCCOMP, rail_err); n_err++;
    end
    repeat (15) @(negedge clk);
    n_vec++;
    if (dualCCOMP !== 1'b1 || fifo_count !== '0) begin
      $display("FAIL midreset_hold: comp %b count %0d want 1 0", dualCCOMP, fifo_count); n_err++;
    end
    dualC = 2'b00;
    send_word(8'h5A, bad);
    n_vec++;
    if (bad != 0 || out_data !== 8'h5A || fifo_count !== CNT_W'(1)) begin
      $display("FAIL midreset_word: bad %0d data %h count %0d want 0 5a 1",
               bad, out_data, fifo_count); n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_word_pack();
    test_backpressure();
    test_push_pop();
    test_rail_error();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
